// File: rtl/decode_stage.sv
// RV64I decode stage: one-cycle decode into a 2-entry (output + skid) buffer.
// Optional RV64M decode is enabled by defining DECODE_RVM_EN.
module decode_stage #(
  parameter int PC_WIDTH  = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [63:0]          out_imm,
  output logic [9:0]           out_alu_type,
  output logic [5:0]           out_cx_type,
  output logic [12:0]          out_muldiv_type,
  output logic [3:0]           out_ls_size,
  output logic                 out_is_load,
  output logic                 out_is_store,
  output logic                 out_is_unsigned,
  output logic                 out_is_word,
  output logic                 out_is_imm,
  output logic                 out_need_to_wb,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] decoded_count
);

  localparam logic [9:0] IS_ADD   = 10'h001;
  localparam logic [9:0] IS_SUB   = 10'h002;
  localparam logic [9:0] IS_SLL   = 10'h004;
  localparam logic [9:0] IS_SLT   = 10'h008;
  localparam logic [9:0] IS_XOR   = 10'h010;
  localparam logic [9:0] IS_SRL   = 10'h020;
  localparam logic [9:0] IS_SRA   = 10'h040;
  localparam logic [9:0] IS_OR    = 10'h080;
  localparam logic [9:0] IS_AND   = 10'h100;
  localparam logic [9:0] IS_AUIPC = 10'h200;

  localparam logic [5:0] IS_JAL  = 6'h01;
  localparam logic [5:0] IS_JALR = 6'h02;
  localparam logic [5:0] IS_BEQ  = 6'h04;
  localparam logic [5:0] IS_BNE  = 6'h08;
  localparam logic [5:0] IS_BLT  = 6'h10;
  localparam logic [5:0] IS_BGE  = 6'h20;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [63:0]         imm;
    logic [9:0]          alu;
    logic [5:0]          cx;
    logic [12:0]         md;
    logic [3:0]          ls;
    logic                ld;
    logic                st;
    logic                uns;
    logic                word;
    logic                isimm;
    logic                wb;
    logic                ill;
  } dec_t;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [63:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_ill, w_wr;
  dec_t        w_dec;

  assign w_op    = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign w_imm_j = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    w_ill     = 1'b0;
    w_wr      = 1'b0;
    w_dec     = '0;
    w_dec.pc  = in_pc;
    w_dec.rs1 = in_instr[19:15];
    w_dec.rs2 = in_instr[24:20];
    w_dec.rd  = in_instr[11:7];
    case (w_op)
      7'b0110111: begin  // LUI computes x0 + imm
        w_dec.alu = IS_ADD; w_dec.isimm = 1'b1; w_dec.imm = w_imm_u; w_dec.rs1 = 5'd0; w_wr = 1'b1;
      end
      7'b0010111: begin
        w_dec.alu = IS_AUIPC; w_dec.isimm = 1'b1; w_dec.imm = w_imm_u; w_wr = 1'b1;
      end
      7'b1101111: begin
        w_dec.cx = IS_JAL; w_dec.imm = w_imm_j; w_wr = 1'b1;
      end
      7'b1100111: begin
        w_dec.cx = IS_JALR; w_dec.imm = w_imm_i; w_wr = 1'b1;
        w_ill = (w_f3 != 3'd0);
      end
      7'b1100011: begin
        w_dec.imm = w_imm_b;
        w_dec.uns = w_f3[1];
        case (w_f3)
          3'd0:         w_dec.cx = IS_BEQ;
          3'd1:         w_dec.cx = IS_BNE;
          3'd4, 3'd6:   w_dec.cx = IS_BLT;
          3'd5, 3'd7:   w_dec.cx = IS_BGE;
          default:      w_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        w_dec.ld = 1'b1; w_dec.isimm = 1'b1; w_dec.imm = w_imm_i; w_wr = 1'b1;
        w_dec.ls = 4'd1 << w_f3[1:0];
        w_dec.uns = w_f3[2];
        w_ill = (w_f3 == 3'd7);
      end
      7'b0100011: begin
        w_dec.st = 1'b1; w_dec.isimm = 1'b1; w_dec.imm = w_imm_s;
        w_dec.ls = 4'd1 << w_f3[1:0];
        w_ill = w_f3[2];
      end
      7'b0010011: begin
        w_dec.isimm = 1'b1; w_dec.imm = w_imm_i; w_wr = 1'b1;
        case (w_f3)
          3'd0: w_dec.alu = IS_ADD;
          3'd1: begin w_dec.alu = IS_SLL; w_ill = (in_instr[31:26] != 6'd0); end
          3'd2: w_dec.alu = IS_SLT;
          3'd3: begin w_dec.alu = IS_SLT; w_dec.uns = 1'b1; end
          3'd4: w_dec.alu = IS_XOR;
          3'd5: begin
            if (in_instr[31:26] == 6'b000000)      w_dec.alu = IS_SRL;
            else if (in_instr[31:26] == 6'b010000) w_dec.alu = IS_SRA;
            else                                   w_ill = 1'b1;
          end
          3'd6: w_dec.alu = IS_OR;
          default: w_dec.alu = IS_AND;
        endcase
      end
      7'b0011011: begin
        w_dec.word = 1'b1; w_dec.isimm = 1'b1; w_dec.imm = w_imm_i; w_wr = 1'b1;
        case (w_f3)
          3'd0: w_dec.alu = IS_ADD;
          3'd1: begin w_dec.alu = IS_SLL; w_ill = (w_f7 != 7'h00); end
          3'd5: begin
            if (w_f7 == 7'h00)      w_dec.alu = IS_SRL;
            else if (w_f7 == 7'h20) w_dec.alu = IS_SRA;
            else                    w_ill = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      7'b0110011: begin
        w_wr = 1'b1;
        case (w_f7)
          7'h00: begin
            case (w_f3)
              3'd0: w_dec.alu = IS_ADD;
              3'd1: w_dec.alu = IS_SLL;
              3'd2: w_dec.alu = IS_SLT;
              3'd3: begin w_dec.alu = IS_SLT; w_dec.uns = 1'b1; end
              3'd4: w_dec.alu = IS_XOR;
              3'd5: w_dec.alu = IS_SRL;
              3'd6: w_dec.alu = IS_OR;
              default: w_dec.alu = IS_AND;
            endcase
          end
          7'h20: begin
            if (w_f3 == 3'd0)      w_dec.alu = IS_SUB;
            else if (w_f3 == 3'd5) w_dec.alu = IS_SRA;
            else                   w_ill = 1'b1;
          end
`ifdef DECODE_RVM_EN
          7'h01: w_dec.md = 13'd1 << w_f3;  // MUL..REMU occupy bits 0..7 in funct3 order
`endif
          default: w_ill = 1'b1;
        endcase
      end
      7'b0111011: begin
        w_wr = 1'b1; w_dec.word = 1'b1;
        case (w_f7)
          7'h00: begin
            if (w_f3 == 3'd0)      w_dec.alu = IS_ADD;
            else if (w_f3 == 3'd1) w_dec.alu = IS_SLL;
            else if (w_f3 == 3'd5) w_dec.alu = IS_SRL;
            else                   w_ill = 1'b1;
          end
          7'h20: begin
            if (w_f3 == 3'd0)      w_dec.alu = IS_SUB;
            else if (w_f3 == 3'd5) w_dec.alu = IS_SRA;
            else                   w_ill = 1'b1;
          end
`ifdef DECODE_RVM_EN
          7'h01: begin  // MULW at bit 8, DIVW..REMUW at bits 9..12
            if (w_f3 == 3'd0)  w_dec.md = 13'h0100;
            else if (w_f3[2])  w_dec.md = 13'd1 << ({1'b0, w_f3} + 4'd5);
            else               w_ill = 1'b1;
          end
`endif
          default: w_ill = 1'b1;
        endcase
      end
      7'b0001111: w_ill = (w_f3 != 3'd0);
      7'b1110011: w_ill = !((in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073));
      default:    w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_dec     = '0;
      w_dec.pc  = in_pc;
      w_dec.rs1 = in_instr[19:15];
      w_dec.rs2 = in_instr[24:20];
      w_dec.rd  = in_instr[11:7];
      w_dec.ill = 1'b1;
    end
    w_dec.wb = w_wr && !w_ill && (in_instr[11:7] != 5'd0);
  end

  dec_t                 r_out, r_skid;
  logic                 r_out_vld, r_skid_vld, r_in_ready;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_acc, w_done;

  assign w_acc  = in_valid && r_in_ready;
  assign w_done = r_out_vld && out_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
      r_cnt      <= '0;
    end else if (flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_done && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      if (!r_out_vld || out_ready) begin
        // in_ready is low whenever the skid is full, so w_acc cannot coincide with a skid move
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_out_vld  <= 1'b1;
          r_skid_vld <= 1'b0;
          r_in_ready <= 1'b1;
        end else begin
          r_out_vld <= w_acc;
          if (w_acc) r_out <= w_dec;
        end
      end else if (w_acc) begin
        r_skid     <= w_dec;
        r_skid_vld <= 1'b1;
        r_in_ready <= 1'b0;
      end
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_vld;
  assign out_pc          = r_out.pc;
  assign out_rs1         = r_out.rs1;
  assign out_rs2         = r_out.rs2;
  assign out_rd          = r_out.rd;
  assign out_imm         = r_out.imm;
  assign out_alu_type    = r_out.alu;
  assign out_cx_type     = r_out.cx;
  assign out_muldiv_type = r_out.md;
  assign out_ls_size     = r_out.ls;
  assign out_is_load     = r_out.ld;
  assign out_is_store    = r_out.st;
  assign out_is_unsigned = r_out.uns;
  assign out_is_word     = r_out.word;
  assign out_is_imm      = r_out.isimm;
  assign out_need_to_wb  = r_out.wb;
  assign out_illegal     = r_out.ill;
  assign decoded_count   = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: mnemonic-level reference model, queue of expected outputs.
`timescale 1ns/1ps
module tb_decode_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, out_valid;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [9:0]  out_alu_type;
  logic [5:0]  out_cx_type;
  logic [12:0] out_muldiv_type;
  logic [3:0]  out_ls_size;
  logic        out_is_load, out_is_store, out_is_unsigned, out_is_word, out_is_imm, out_need_to_wb, out_illegal;
  logic [31:0] decoded_count;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_pc, s_out_imm;
  logic [4:0]  s_out_rs1, s_out_rs2, s_out_rd;
  logic [9:0]  s_out_alu_type;
  logic [5:0]  s_out_cx_type;
  logic [12:0] s_out_muldiv_type;
  logic [3:0]  s_out_ls_size;
  logic        s_out_is_load, s_out_is_store, s_out_is_unsigned, s_out_is_word, s_out_is_imm, s_out_need_to_wb, s_out_illegal;
  logic [1:0]  s_decoded_count;

  decode_stage #(.PC_WIDTH(64), .CNT_WIDTH(32)) u_dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_type(out_alu_type), .out_cx_type(out_cx_type), .out_muldiv_type(out_muldiv_type),
    .out_ls_size(out_ls_size), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_unsigned(out_is_unsigned), .out_is_word(out_is_word), .out_is_imm(out_is_imm),
    .out_need_to_wb(out_need_to_wb), .out_illegal(out_illegal), .decoded_count(decoded_count));

  decode_stage #(.PC_WIDTH(64), .CNT_WIDTH(2)) u_sat (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_rd(s_out_rd), .out_imm(s_out_imm),
    .out_alu_type(s_out_alu_type), .out_cx_type(s_out_cx_type), .out_muldiv_type(s_out_muldiv_type),
    .out_ls_size(s_out_ls_size), .out_is_load(s_out_is_load), .out_is_store(s_out_is_store),
    .out_is_unsigned(s_out_is_unsigned), .out_is_word(s_out_is_word), .out_is_imm(s_out_is_imm),
    .out_need_to_wb(s_out_need_to_wb), .out_illegal(s_out_illegal), .decoded_count(s_decoded_count));

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [9:0]  alu;
    logic [5:0]  cx;
    logic [12:0] md;
    logic [3:0]  ls;
    logic        ld, st, uns, word, isimm, wb, ill;
  } exp_t;

  exp_t act_m, act_s;
  assign act_m = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_type, out_cx_type, out_muldiv_type,
                  out_ls_size, out_is_load, out_is_store, out_is_unsigned, out_is_word, out_is_imm,
                  out_need_to_wb, out_illegal};
  assign act_s = {s_out_pc, s_out_rs1, s_out_rs2, s_out_rd, s_out_imm, s_out_alu_type, s_out_cx_type,
                  s_out_muldiv_type, s_out_ls_size, s_out_is_load, s_out_is_store, s_out_is_unsigned,
                  s_out_is_word, s_out_is_imm, s_out_need_to_wb, s_out_illegal};

  typedef enum {M_ILL, M_NOP, M_LUI, M_AUIPC, M_JAL, M_JALR, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
                M_LB, M_LH, M_LW, M_LD, M_LBU, M_LHU, M_LWU, M_SB, M_SH, M_SW, M_SD,
                M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
                M_ADDIW, M_SLLIW, M_SRLIW, M_SRAIW,
                M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
                M_ADDW, M_SUBW, M_SLLW, M_SRLW, M_SRAW,
                M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU,
                M_MULW, M_DIVW, M_DIVUW, M_REMW, M_REMUW} mn_t;

  function automatic mn_t ident(input logic [31:0] ins);
    int f3, f7, key;
    mn_t m;
    f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); key = f7 * 8 + f3;
    m = M_ILL;
    case (ins[6:0])
      7'h37: m = M_LUI;
      7'h17: m = M_AUIPC;
      7'h6F: m = M_JAL;
      7'h67: if (f3 == 0) m = M_JALR;
      7'h63: case (f3) 0: m = M_BEQ; 1: m = M_BNE; 4: m = M_BLT; 5: m = M_BGE; 6: m = M_BLTU; 7: m = M_BGEU; default: ; endcase
      7'h03: case (f3) 0: m = M_LB; 1: m = M_LH; 2: m = M_LW; 3: m = M_LD; 4: m = M_LBU; 5: m = M_LHU; 6: m = M_LWU; default: ; endcase
      7'h23: case (f3) 0: m = M_SB; 1: m = M_SH; 2: m = M_SW; 3: m = M_SD; default: ; endcase
      7'h13: case (f3)
        0: m = M_ADDI; 2: m = M_SLTI; 3: m = M_SLTIU; 4: m = M_XORI; 6: m = M_ORI; 7: m = M_ANDI;
        1: if (ins[31:26] == 0) m = M_SLLI;
        default: if (ins[31:26] == 0) m = M_SRLI; else if (ins[31:26] == 16) m = M_SRAI;
      endcase
      7'h1B: if (key == 0) m = M_ADDIW; else if (key == 1) m = M_SLLIW; else if (key == 5) m = M_SRLIW;
             else if (key == 261) m = M_SRAIW; else if (f3 == 0) m = M_ADDIW;
      7'h33: case (key)
        0: m = M_ADD; 1: m = M_SLL; 2: m = M_SLT; 3: m = M_SLTU; 4: m = M_XOR; 5: m = M_SRL; 6: m = M_OR; 7: m = M_AND;
        256: m = M_SUB; 261: m = M_SRA;
`ifdef DECODE_RVM_EN
        8: m = M_MUL; 9: m = M_MULH; 10: m = M_MULHSU; 11: m = M_MULHU;
        12: m = M_DIV; 13: m = M_DIVU; 14: m = M_REM; 15: m = M_REMU;
`endif
        default: ;
      endcase
      7'h3B: case (key)
        0: m = M_ADDW; 1: m = M_SLLW; 5: m = M_SRLW; 256: m = M_SUBW; 261: m = M_SRAW;
`ifdef DECODE_RVM_EN
        8: m = M_MULW; 12: m = M_DIVW; 13: m = M_DIVUW; 14: m = M_REMW; 15: m = M_REMUW;
`endif
        default: ;
      endcase
      7'h0F: if (f3 == 0) m = M_NOP;
      7'h73: if (ins == 32'h73 || ins == 32'h0010_0073) m = M_NOP;
      default: ;
    endcase
    return m;
  endfunction

  // alu bits: ADD SUB SLL SLT XOR SRL SRA OR AND AUIPC; cx: JAL JALR BEQ BNE BLT BGE
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    mn_t m;
    logic signed [31:0] si;
    longint hi20, hi25, hi31, hi12;
    int a, c, d, s, fmt;
    bit wr;
    si = ins; hi20 = si >>> 20; hi25 = si >>> 25; hi31 = si >>> 31; hi12 = si >>> 12;
    e = '0; e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    a = -1; c = -1; d = -1; s = -1; fmt = 0; wr = 0;
    m = ident(ins);
    case (m)
      M_ILL: e.ill = 1;
      M_NOP: ;
      M_LUI:   begin a = 0; fmt = 4; e.isimm = 1; wr = 1; e.rs1 = 0; end
      M_AUIPC: begin a = 9; fmt = 4; e.isimm = 1; wr = 1; end
      M_JAL:   begin c = 0; fmt = 5; wr = 1; end
      M_JALR:  begin c = 1; fmt = 1; wr = 1; end
      M_BEQ: begin c = 2; fmt = 3; end
      M_BNE: begin c = 3; fmt = 3; end
      M_BLT, M_BLTU: begin c = 4; fmt = 3; e.uns = (m == M_BLTU); end
      M_BGE, M_BGEU: begin c = 5; fmt = 3; e.uns = (m == M_BGEU); end
      M_LB, M_LBU: begin s = 0; e.uns = (m == M_LBU); end
      M_LH, M_LHU: begin s = 1; e.uns = (m == M_LHU); end
      M_LW, M_LWU: begin s = 2; e.uns = (m == M_LWU); end
      M_LD: s = 3;
      M_SB: s = 0; M_SH: s = 1; M_SW: s = 2; M_SD: s = 3;
      M_ADDI, M_ADDIW, M_ADD, M_ADDW: a = 0;
      M_SUB, M_SUBW: a = 1;
      M_SLLI, M_SLLIW, M_SLL, M_SLLW: a = 2;
      M_SLTI, M_SLT: a = 3;
      M_SLTIU, M_SLTU: begin a = 3; e.uns = 1; end
      M_XORI, M_XOR: a = 4;
      M_SRLI, M_SRLIW, M_SRL, M_SRLW: a = 5;
      M_SRAI, M_SRAIW, M_SRA, M_SRAW: a = 6;
      M_ORI, M_OR: a = 7;
      M_ANDI, M_AND: a = 8;
      M_MUL: d = 0; M_MULH: d = 1; M_MULHSU: d = 2; M_MULHU: d = 3;
      M_DIV: d = 4; M_DIVU: d = 5; M_REM: d = 6; M_REMU: d = 7;
      M_MULW: d = 8; M_DIVW: d = 9; M_DIVUW: d = 10; M_REMW: d = 11; M_REMUW: d = 12;
      default: ;
    endcase
    if (m >= M_LB && m <= M_LWU) begin e.ld = 1; fmt = 1; e.isimm = 1; wr = 1; end
    if (m >= M_SB && m <= M_SD) begin e.st = 1; fmt = 2; e.isimm = 1; end
    if (m >= M_ADDI && m <= M_SRAIW) begin fmt = 1; e.isimm = 1; wr = 1; end
    if (m >= M_ADD && m <= M_REMUW) wr = 1;
    if ((m >= M_ADDIW && m <= M_SRAIW) || (m >= M_ADDW && m <= M_SRAW) || (m >= M_MULW)) e.word = 1;
    case (fmt)
      1: e.imm = hi20;
      2: e.imm = hi25 * 32 + ins[11:7];
      3: e.imm = hi31 * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
      4: e.imm = hi12 * 4096;
      5: e.imm = hi31 * (64'd1 << 20) + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
      default: e.imm = 0;
    endcase
    if (a >= 0) e.alu = 10'd1 << a;
    if (c >= 0) e.cx = 6'd1 << c;
    if (d >= 0) e.md = 13'd1 << d;
    if (s >= 0) e.ls = 4'd1 << s;
    e.wb = wr && (ins[11:7] != 0);
    return e;
  endfunction

  int   tests = 0, fails = 0, n = 0;
  bit   armed = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // monitor: occupancy, counters and head-of-queue payload
  always @(negedge clock) begin
    if (armed) begin
      chk("out_valid", 256'(out_valid), 256'(q.size() != 0));
      chk("in_ready", 256'(in_ready), 256'(q.size() < 2));
      chk("sat_handshake", 256'({s_out_valid, s_in_ready}), 256'({q.size() != 0, q.size() < 2}));
      chk("count", 256'(decoded_count), 256'(n));
      chk("sat_count", 256'(s_decoded_count), 256'(n > 3 ? 3 : n));
      if (out_valid && q.size() > 0) begin
        chk("payload", 256'(act_m), 256'(q[0]));
        chk("sat_payload", 256'(act_s), 256'(q[0]));
      end
      if (out_valid && out_ready && reset_n && !flush && q.size() > 0) begin
        void'(q.pop_front());
        n++;
      end
      if (!reset_n || flush) q.delete();
      if (!reset_n) n = 0;
    end
  end

  // record each accepted instruction's expected decode
  always @(negedge clock) begin
    #2;
    if (armed && reset_n && !flush && in_valid && in_ready) q.push_back(model(in_instr, in_pc));
  end

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    int k;
    in_valid = 1'b1; in_instr = ins; in_pc = pc; k = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      k++;
      if (k > 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] r;
    int k;
    r = $urandom; k = $urandom_range(0, 13);
    case (k)
      0: r[6:0] = 7'h37; 1: r[6:0] = 7'h17; 2: r[6:0] = 7'h6F; 3: r[6:0] = 7'h67; 4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h03; 6: r[6:0] = 7'h23; 7: r[6:0] = 7'h13; 8: r[6:0] = 7'h1B; 9: r[6:0] = 7'h33;
      10: r[6:0] = 7'h3B; 11: r[6:0] = 7'h0F; 12: r[6:0] = 7'h73; default: ;
    endcase
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00; 1: r[31:25] = 7'h20; 2: r[31:25] = 7'h01; default: ;
    endcase
    if (k == 11 && $urandom_range(0, 1) == 1) r[14:12] = 3'd0;
    if (k == 12 && $urandom_range(0, 1) == 1) r = ($urandom_range(0, 1) == 1) ? 32'h73 : 32'h0010_0073;
    return r;
  endfunction

  bit done;

  initial begin
    reset_n = 0; flush = 0; in_valid = 0; out_ready = 1; in_instr = 0; in_pc = 0;
    @(posedge clock); #1;
    armed = 1;
    @(posedge clock); #1;
    reset_n = 1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_count", 256'(decoded_count), 256'(0));
    chk("rst_payload", 256'(act_m), 256'(0));

    send(32'hFFF0_0293, 64'h1000);
    chk("addi_valid", 256'(out_valid), 256'(1));
    chk("addi_rd", 256'(out_rd), 256'(5));
    chk("addi_imm", 256'(out_imm), 256'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("addi_fields", 256'({out_alu_type, out_is_imm, out_need_to_wb}), 256'({10'h001, 1'b1, 1'b1}));
    send(32'h0020_8033, 64'h1004);
    chk("add_x0", 256'({out_alu_type, out_need_to_wb, out_illegal}), 256'({10'h001, 1'b0, 1'b0}));
    send(32'h0231_00B3, 64'h1008);
`ifdef DECODE_RVM_EN
    chk("mul", 256'({out_muldiv_type, out_rd, out_illegal}), 256'({13'h0001, 5'd1, 1'b0}));
`else
    chk("mul_illegal", 256'({out_muldiv_type, out_illegal}), 256'({13'h0, 1'b1}));
`endif
    send(32'h0000_007F, 64'h100C);
    chk("bad_opcode", 256'({out_alu_type, out_cx_type, out_muldiv_type, out_ls_size, out_illegal}),
        256'({10'h0, 6'h0, 13'h0, 4'h0, 1'b1}));
    send(32'h0000_000F, 64'h1010);
    repeat (2) @(posedge clock); #1;
    chk("count5", 256'(decoded_count), 256'(5));
    chk("sat_count5", 256'(s_decoded_count), 256'(3));

    // stall: A, B fill both entries, C waits until the output drains
    out_ready = 0;
    send(32'h0010_0093, 64'h2000);
    send(32'h0020_0113, 64'h2004);
    in_valid = 1; in_instr = 32'h0030_0193; in_pc = 64'h2008;
    chk("stall_in_ready", 256'(in_ready), 256'(0));
    repeat (3) @(posedge clock); #1;
    chk("stall_hold_pc", 256'(out_pc), 256'(64'h2000));
    chk("stall_in_ready2", 256'(in_ready), 256'(0));
    out_ready = 1;
    send(32'h0030_0193, 64'h2008);
    repeat (4) @(posedge clock); #1;
    chk("count8", 256'(decoded_count), 256'(8));

    // flush with both entries full and an instruction on offer
    out_ready = 0;
    send(32'h0040_0213, 64'h3000);
    send(32'h0050_0293, 64'h3004);
    in_valid = 1; in_instr = 32'h0060_0313; in_pc = 64'h3008; flush = 1;
    @(posedge clock); #1;
    flush = 0; in_valid = 0;
    chk("flush_valid", 256'(out_valid), 256'(0));
    chk("flush_ready", 256'(in_ready), 256'(1));
    chk("flush_count", 256'(decoded_count), 256'(8));

    // reset mid-transfer overrides flush and handshakes
    send(32'h0070_0393, 64'h4000);
    send(32'h0080_0413, 64'h4004);
    in_valid = 1; flush = 1; out_ready = 1; reset_n = 0;
    @(posedge clock); #1;
    reset_n = 1; flush = 0; in_valid = 0;
    chk("mid_rst_state", 256'({out_valid, in_ready}), 256'({1'b0, 1'b1}));
    chk("mid_rst_count", 256'(decoded_count), 256'(0));
    chk("mid_rst_payload", 256'(act_m), 256'(0));

    done = 0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(0, 40) == 0) begin
            flush = 1; in_valid = $urandom_range(0, 1); in_instr = gen(); in_pc = {$urandom, $urandom};
            @(posedge clock); #1;
            flush = 0; in_valid = 0;
          end else if ($urandom_range(0, 5) == 0) begin
            @(posedge clock); #1;
          end else begin
            send(gen(), {$urandom, $urandom});
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clock); #1;
        end
      end
    join
    out_ready = 1; in_valid = 0;
    repeat (5) @(posedge clock); #1;
    chk("drained", 256'(q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
